seal_verifier: RTL and testbench

//  Consumer end of the seal-record protocol. Software loads a 3-word sealed record {value, {sid,mono[23:0]}, {mono[31:24],crc16,8'h00}}.
//  A start command supplies sensor_id. The block re-feeds the same 9 bytes through the shared CRC16 engine and compares the result with the record CRC.
//  It also enforces monotonic ordering and a single session ID against the last accepted record, and keeps pass/fail tallies.

---
 rtl/seal_pkg.sv | 72 +++++++
 rtl/seal_byte_feeder.sv | 55 +++++
 rtl/seal_verifier.sv | 220 ++++++++++++++++++++++
 tb/tb_seal_verifier.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seal_pkg.sv
// seal_pkg: shared definitions for the seal-record protocol (verifier side).
// FSM state encoding, stat_out bit positions, record word field offsets,
// the result-flag bundle and the 9-byte CRC feed order shared with seal_register.
package seal_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        FEED  = 2'd2,
        CHECK = 2'd3
    } seal_state_t;

    // stat_out bit positions (pass_count occupies the top CNT_W bits)
    localparam int STAT_BUSY     = 0;
    localparam int STAT_PASS     = 1;
    localparam int STAT_CRC_ERR  = 2;
    localparam int STAT_MONO_ERR = 3;
    localparam int STAT_SID_ERR  = 4;
    localparam int STAT_GAP_ERR  = 5;
    localparam int STAT_FMT_ERR  = 6;
    localparam int STAT_TMO_ERR  = 7;

    // Record word field offsets
    localparam int SID_HI    = 31;
    localparam int SID_LO    = 24;
    localparam int MONO_LO_W = 24;   // word1 carries mono[23:0], word2 carries mono[31:24]
    localparam int CRC_LSB   = 8;
    localparam int CRC_MSB   = 23;

    // Index of the last byte in the 9-byte feed sequence
    localparam logic [3:0] SEAL_LAST_IDX = 4'd8;

    // Result flags, ordered to match stat_out[STAT_TMO_ERR:STAT_PASS]
    typedef struct packed {
        logic tmo_err;
        logic fmt_err;
        logic gap_err;
        logic sid_err;
        logic mono_err;
        logic crc_err;
        logic pass;
    } seal_flags_t;

    // Byte order fed to the CRC engine: sid, value LSB..MSB, mono LSB..MSB
    function automatic logic [7:0] seal_byte_sel(
        input logic [3:0]  idx,
        input logic [7:0]  sid,
        input logic [31:0] value,
        input logic [31:0] mono
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = sid;
            4'd1:    b = value[7:0];
            4'd2:    b = value[15:8];
            4'd3:    b = value[23:16];
            4'd4:    b = value[31:24];
            4'd5:    b = mono[7:0];
            4'd6:    b = mono[15:8];
            4'd7:    b = mono[23:16];
            4'd8:    b = mono[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Reassemble the 32-bit monotonic counter split across word1 and word2
    function automatic logic [31:0] seal_mono(input logic [31:0] w1, input logic [31:0] w2);
        return {w2[31:MONO_LO_W], w1[MONO_LO_W-1:0]};
    endfunction

endpackage

// File: rtl/seal_byte_feeder.sv
// seal_byte_feeder: walks the 9 record bytes into the shared CRC16 engine.
// Handshake: a byte is presented with a one-cycle crc_feed strobe only while
// crc_busy is low; the feeder then waits for crc_busy low again before moving
// to the next byte. done pulses once the last byte has been accepted.
// restart returns the walk to byte 0 and is expected one cycle before en.
module seal_byte_feeder
    import seal_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        en,
    input  logic        crc_busy,
    input  logic [7:0]  sid,
    input  logic [31:0] value,
    input  logic [31:0] mono,
    output logic [7:0]  crc_byte,
    output logic        crc_feed,
    output logic        done
);

    logic [3:0] idx;
    logic       sent;

    // Byte index and sent flag advance only when the engine is free
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            idx  <= 4'd0;
            sent <= 1'b0;
        end else if (en && !crc_busy) begin
            if (!sent) begin
                sent <= 1'b1;
            end else if (idx != SEAL_LAST_IDX) begin
                idx  <= idx + 4'd1;
                sent <= 1'b0;
            end
        end
    end

    // Present the current byte with a feed strobe, or signal completion
    always_comb begin
        crc_byte = 8'h00;
        crc_feed = 1'b0;
        done     = 1'b0;
        if (en && !crc_busy) begin
            if (!sent) begin
                crc_byte = seal_byte_sel(idx, sid, value, mono);
                crc_feed = 1'b1;
            end else if (idx == SEAL_LAST_IDX) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seal_verifier.sv
// seal_verifier: consumer end of the seal-record protocol.
// Software loads three record words, then issues a start with the sensor id.
// The record is re-fed through the shared CRC16 engine and checked for CRC,
// monotonic ordering and session id against the last accepted record;
// pass/fail tallies saturate at 2^CNT_W-1 (CNT_W must not exceed 24).
// Optional feature macro: SEAL_GAP_DETECT_EN -- when defined, an accepted
// record must carry exactly last_mono+1; otherwise gap_err is tied to 0.
// dbg_state exposes the FSM state for observation.
module seal_verifier
    import seal_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int CRC_TMO = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  crc_byte,
    output logic        crc_feed,
    output logic        crc_init,
    input  logic        crc_busy,
    input  logic [15:0] crc_value,
    input  logic        data_wr,
    input  logic [31:0] data_in,
    input  logic        ctrl_wr,
    input  logic [9:0]  ctrl_in,
    output logic [31:0] stat_out,
    output logic [31:0] fail_out,
    output seal_state_t dbg_state
);

    localparam int TMO_W = $clog2(CRC_TMO + 1);

    seal_state_t      state, state_next;
    logic [31:0]      word0, word1, word2;
    logic [1:0]       wr_idx;
    logic [7:0]       sid_q;
    logic             have_last;
    logic [31:0]      last_mono;
    logic [7:0]       last_sid;
    logic [CNT_W-1:0] pass_count, fail_count;
    seal_flags_t      flags;
    logic [TMO_W-1:0] tmo_cnt;

    logic        feed_en, feed_restart, feed_done;
    logic        tmo_hit, check_fire, run_end;
    logic        ctrl_clear, ctrl_start, fmt_ok, ctrl_go, ctrl_fmt_bad;
    logic [31:0] mono;
    logic [7:0]  rec_sid;
    logic        chk_crc_err, chk_mono_err, chk_sid_err, chk_gap_err, chk_pass;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Command decode: only honoured in IDLE; clear wins over start
    always_comb begin
        ctrl_clear   = (state == IDLE) && ctrl_wr && ctrl_in[0];
        ctrl_start   = (state == IDLE) && ctrl_wr && !ctrl_in[0] && ctrl_in[1];
        fmt_ok       = (wr_idx == 2'd3) && (word2[CRC_LSB-1:0] == 8'h00);
        ctrl_go      = ctrl_start && fmt_ok;
        ctrl_fmt_bad = ctrl_start && !fmt_ok;
    end

    // Record field extraction and the acceptance checks against history
    always_comb begin
        mono         = seal_mono(word1, word2);
        rec_sid      = word1[SID_HI:SID_LO];
        chk_crc_err  = crc_value != word2[CRC_MSB:CRC_LSB];
        chk_mono_err = have_last && (mono <= last_mono);
        chk_sid_err  = have_last && (rec_sid != last_sid);
`ifdef SEAL_GAP_DETECT_EN
        chk_gap_err  = have_last && (mono != last_mono + 32'd1);
`else
        chk_gap_err  = 1'b0;
`endif
        chk_pass     = !(chk_crc_err || chk_mono_err || chk_sid_err || chk_gap_err);
    end

    // A busy engine in FEED/CHECK for CRC_TMO consecutive cycles aborts the run
    always_comb begin
        tmo_hit = ((state == FEED) || (state == CHECK)) && crc_busy &&
                  (tmo_cnt == TMO_W'(CRC_TMO - 1));
    end

    // FSM next-state and engine control
    always_comb begin
        state_next   = state;
        crc_init     = 1'b0;
        feed_en      = 1'b0;
        feed_restart = 1'b0;
        check_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_go) state_next = INIT;
            end
            INIT: begin
                crc_init     = 1'b1;
                feed_restart = 1'b1;
                state_next   = FEED;
            end
            FEED: begin
                feed_en = 1'b1;
                if (tmo_hit)        state_next = IDLE;
                else if (feed_done) state_next = CHECK;
            end
            CHECK: begin
                if (tmo_hit) begin
                    state_next = IDLE;
                end else if (!crc_busy) begin
                    check_fire = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        run_end = (state != IDLE) && (state_next == IDLE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Per-byte busy-wait counter, restarted whenever the engine is free
    always_ff @(posedge clk) begin
        if (rst || !((state == FEED) || (state == CHECK)) || !crc_busy)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Record word loading; a finished run forces the next record to be reloaded
    always_ff @(posedge clk) begin
        if (rst) begin
            word0  <= '0;
            word1  <= '0;
            word2  <= '0;
            wr_idx <= '0;
        end else begin
            if ((state == IDLE) && data_wr && (wr_idx != 2'd3)) begin
                case (wr_idx)
                    2'd0:    word0 <= data_in;
                    2'd1:    word1 <= data_in;
                    default: word2 <= data_in;
                endcase
                wr_idx <= wr_idx + 2'd1;
            end
            if (ctrl_clear || run_end) wr_idx <= '0;
        end
    end

    // Result flags, tallies and accepted-record history
    always_ff @(posedge clk) begin
        if (rst) begin
            flags      <= '0;
            pass_count <= '0;
            fail_count <= '0;
            have_last  <= 1'b0;
            last_mono  <= '0;
            last_sid   <= '0;
            sid_q      <= '0;
        end else if (ctrl_clear) begin
            flags      <= '0;
            pass_count <= '0;
            fail_count <= '0;
            have_last  <= 1'b0;
        end else if (ctrl_fmt_bad) begin
            flags         <= '0;
            flags.fmt_err <= 1'b1;
            fail_count    <= sat_inc(fail_count);
        end else if (ctrl_go) begin
            flags <= '0;
            sid_q <= ctrl_in[9:2];
        end else if (tmo_hit) begin
            flags.tmo_err <= 1'b1;
            fail_count    <= sat_inc(fail_count);
        end else if (check_fire) begin
            flags.crc_err  <= chk_crc_err;
            flags.mono_err <= chk_mono_err;
            flags.sid_err  <= chk_sid_err;
            flags.gap_err  <= chk_gap_err;
            flags.pass     <= chk_pass;
            if (chk_pass) begin
                pass_count <= sat_inc(pass_count);
                have_last  <= 1'b1;
                last_mono  <= mono;
                last_sid   <= rec_sid;
            end else begin
                fail_count <= sat_inc(fail_count);
            end
        end
    end

    seal_byte_feeder u_feeder (
        .clk      (clk),
        .rst      (rst),
        .restart  (feed_restart),
        .en       (feed_en),
        .crc_busy (crc_busy),
        .sid      (sid_q),
        .value    (word0),
        .mono     (mono),
        .crc_byte (crc_byte),
        .crc_feed (crc_feed),
        .done     (feed_done)
    );

    // Status register views
    always_comb begin
        stat_out                           = '0;
        stat_out[STAT_BUSY]                = (state != IDLE);
        stat_out[STAT_TMO_ERR:STAT_PASS]   = flags;
        stat_out[31 -: CNT_W]              = pass_count;
        fail_out                           = '0;
        fail_out[CNT_W-1:0]                = fail_count;
        dbg_state                          = state;
    end

endmodule

// File: tb/tb_seal_verifier.sv
// tb_seal_verifier: directed + randomized checks of seal_verifier against a
// record-level reference model, with a behavioural CRC16 engine (CCITT, 0x1021).
module tb_seal_verifier;
    import seal_pkg::*;

    localparam int          CNT_W   = 5;
    localparam int          CRC_TMO = 64;
    localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  crc_byte;
    logic        crc_feed, crc_init, crc_busy;
    logic [15:0] crc_value;
    logic        data_wr, ctrl_wr;
    logic [31:0] data_in;
    logic [9:0]  ctrl_in;
    logic [31:0] stat_out, fail_out;
    seal_state_t dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    // reference model history
    logic        m_have;
    logic [31:0] m_last_mono;
    logic [7:0]  m_last_sid;
    logic [31:0] m_pass, m_fail;

    // CRC engine model
    logic [15:0] crc_reg;
    logic [1:0]  busy_cnt;
    logic        stall_en, force_busy;
    int          run_feeds, total_feeds;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    seal_verifier #(.CNT_W(CNT_W), .CRC_TMO(CRC_TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .crc_byte  (crc_byte),
        .crc_feed  (crc_feed),
        .crc_init  (crc_init),
        .crc_busy  (crc_busy),
        .crc_value (crc_value),
        .data_wr   (data_wr),
        .data_in   (data_in),
        .ctrl_wr   (ctrl_wr),
        .ctrl_in   (ctrl_in),
        .stat_out  (stat_out),
        .fail_out  (fail_out),
        .dbg_state (dbg_state)
    );

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Behavioural shared CRC16 engine with optional random busy stretches
    assign crc_busy  = (busy_cnt != 2'd0) || force_busy;
    assign crc_value = crc_reg;

    always @(posedge clk) begin
        if (crc_feed) total_feeds <= total_feeds + 1;
        if (rst) begin
            crc_reg   <= 16'h0000;
            busy_cnt  <= 2'd0;
            run_feeds <= 0;
        end else if (crc_init) begin
            crc_reg   <= 16'hFFFF;
            run_feeds <= 0;
        end else if (crc_feed) begin
            crc_reg   <= crc_upd(crc_reg, crc_byte);
            run_feeds <= run_feeds + 1;
            busy_cnt  <= stall_en ? 2'($urandom_range(0, 2)) : 2'd0;
        end else if (busy_cnt != 2'd0) begin
            busy_cnt <= busy_cnt - 2'd1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] record_crc(input logic [7:0] sid, input logic [31:0] value,
                                               input logic [31:0] mono);
        logic [7:0]  b [9];
        logic [15:0] c;
        b[0] = sid;
        for (int i = 0; i < 4; i++) begin
            b[1 + i] = value[8*i +: 8];
            b[5 + i] = mono[8*i +: 8];
        end
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = crc_upd(c, b[i]);
        return c;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

    function automatic logic [63:0] exp_word(input logic tmo, input logic fmt, input logic gap,
                                             input logic sid, input logic mon, input logic crc,
                                             input logic pas);
        logic [31:0] st;
        st = (m_pass << (32 - CNT_W)) | (32'(tmo) << 7) | (32'(fmt) << 6) | (32'(gap) << 5) |
             (32'(sid) << 4) | (32'(mon) << 3) | (32'(crc) << 2) | (32'(pas) << 1);
        return {m_fail, st};
    endfunction

    task automatic model_reset();
        m_have = 1'b0; m_last_mono = '0; m_last_sid = '0; m_pass = '0; m_fail = '0;
    endtask

    task automatic model_clear();
        m_have = 1'b0; m_pass = '0; m_fail = '0;
        exp_q.push_back(exp_word(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic model_run(input logic [7:0] cmd_sid, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] mono;
        logic        e_crc, e_mono, e_sid, e_gap, ok;
        mono   = {w2[31:24], w1[23:0]};
        e_crc  = record_crc(cmd_sid, w0, mono) != w2[23:8];
        e_mono = m_have && (mono <= m_last_mono);
        e_sid  = m_have && (w1[31:24] != m_last_sid);
        e_gap  = 1'b0;
`ifdef SEAL_GAP_DETECT_EN
        e_gap  = m_have && (mono != m_last_mono + 32'd1);
`endif
        ok = !(e_crc || e_mono || e_sid || e_gap);
        if (ok) begin
            m_pass = sat(m_pass); m_have = 1'b1; m_last_mono = mono; m_last_sid = w1[31:24];
        end else begin
            m_fail = sat(m_fail);
        end
        exp_q.push_back(exp_word(0, 0, e_gap, e_sid, e_mono, e_crc, ok));
    endtask

    task automatic make_record(input logic [7:0] sid, input logic [31:0] value, input logic [31:0] mono,
                               output logic [31:0] w0, output logic [31:0] w1, output logic [31:0] w2);
        w0 = value;
        w1 = {sid, mono[23:0]};
        w2 = {mono[31:24], record_crc(sid, value, mono), 8'h00};
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sb(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            chk(tag, {fail_out, stat_out}, exp_q.pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    task automatic write_word(input logic [31:0] w);
        @(negedge clk); data_wr = 1'b1; data_in = w;
        @(negedge clk); data_wr = 1'b0;
    endtask

    task automatic pulse_ctrl(input logic [7:0] sid, input logic st, input logic cl);
        @(negedge clk); ctrl_wr = 1'b1; ctrl_in = {sid, st, cl};
        @(posedge clk); #1; ctrl_wr = 1'b0; ctrl_in = '0;
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (stat_out[0] === 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_idle_bound"}, 64'(stat_out[0]), 64'd0);
    endtask

    task automatic wait_feeds(input string tag, input int n);
        int k;
        k = 0;
        @(posedge clk); #1;
        while (run_feeds < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_feed_bound"}, 64'(run_feeds >= n), 64'd1);
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        write_word(w0); write_word(w1); write_word(w2);
    endtask

    task automatic run_record(input string tag, input logic [7:0] cmd_sid, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, output int lat);
        load(w0, w1, w2);
        pulse_ctrl(cmd_sid, 1'b1, 1'b0);
        wait_idle(tag, lat);
        model_run(cmd_sid, w0, w1, w2);
        chk_sb(tag);
        chk({tag, "_feeds"}, 64'(run_feeds), 64'd9);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] w0, w1, w2, val, mono, base;
        logic [7:0]  rsid, csid;
        int          lat, kind, tf;

        rst = 1'b1; data_wr = 1'b0; data_in = '0; ctrl_wr = 1'b0; ctrl_in = '0;
        stall_en = 1'b0; force_busy = 1'b0; total_feeds = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stat", 64'(stat_out), 64'd0);
        chk("reset_fail", 64'(fail_out), 64'd0);
        chk("reset_crc_if", 64'({crc_byte, crc_feed, crc_init}), 64'd0);
        @(negedge clk); rst = 1'b0;

        // basic seal/verify, ideal engine
        make_record(8'h12, 32'hDEADBEEF, 32'd0, w0, w1, w2);
        run_record("basic", 8'h12, w0, w1, w2, lat);
        chk("basic_latency", 64'(lat), 64'd20);
        chk("basic_pass_bit", 64'(stat_out[1]), 64'd1);
        chk("basic_pass_count", 64'(stat_out[31 -: CNT_W]), 64'd1);

        // corrupted value -> crc_err, history untouched
        stall_en = 1'b1;
        run_record("crc_flip", 8'h12, w0 ^ 32'd1, w1, w2, lat);
        chk("crc_flip_err", 64'(stat_out[2]), 64'd1);
        chk("crc_flip_fail_count", 64'(fail_out), 64'd1);

        // ordering: accept 1, repeat 1, then skip to 3
        make_record(8'h12, $urandom(), 32'd1, w0, w1, w2);
        run_record("mono_1", 8'h12, w0, w1, w2, lat);
        run_record("mono_repeat", 8'h12, w0, w1, w2, lat);
        chk("mono_repeat_err", 64'(stat_out[3]), 64'd1);
        make_record(8'h12, $urandom(), 32'd3, w0, w1, w2);
        run_record("mono_skip", 8'h12, w0, w1, w2, lat);
`ifdef SEAL_GAP_DETECT_EN
        chk("mono_skip_gap", 64'(stat_out[5]), 64'd1);
`else
        chk("mono_skip_pass", 64'(stat_out[1]), 64'd1);
`endif
        make_record(8'h34, $urandom(), m_last_mono + 32'd1, w0, w1, w2);
        run_record("sid_change", 8'h34, w0, w1, w2, lat);
        chk("sid_change_err", 64'(stat_out[4]), 64'd1);

        // randomized records against the model
        for (int i = 0; i < 14; i++) begin
            kind = int'($urandom_range(0, 5));
            val  = $urandom();
            base = m_last_mono;
            rsid = m_last_sid;
            mono = base + 32'd1;
            if (kind == 1) mono = base + 32'($urandom_range(2, 6));
            if (kind == 2) mono = base;
            if (kind == 3) rsid = m_last_sid ^ 8'h5A;
            make_record(rsid, val, mono, w0, w1, w2);
            csid = rsid;
            if (kind == 4) w0 = w0 ^ (32'd1 << $urandom_range(0, 31));
            if (kind == 5) csid = rsid ^ 8'h01;
            run_record("random", csid, w0, w1, w2, lat);
        end

        // timeout: engine stuck busy after byte 3
        stall_en = 1'b0;
        make_record(m_last_sid, $urandom(), m_last_mono + 32'd1, w0, w1, w2);
        load(w0, w1, w2);
        pulse_ctrl(m_last_sid, 1'b1, 1'b0);
        wait_feeds("tmo", 4);
        force_busy = 1'b1;
        wait_idle("tmo", lat);
        m_fail = sat(m_fail);
        exp_q.push_back(exp_word(1, 0, 0, 0, 0, 0, 0));
        chk_sb("tmo");
        chk("tmo_err_bit", 64'(stat_out[7]), 64'd1);
        chk("tmo_busy_low", 64'(stat_out[0]), 64'd0);
        @(negedge clk); force_busy = 1'b0;

        // reset in the middle of FEED
        load(w0, w1, w2);
        pulse_ctrl(m_last_sid, 1'b1, 1'b0);
        wait_feeds("midrst", 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_stat", 64'(stat_out), 64'd0);
        chk("midrst_fail", 64'(fail_out), 64'd0);
        chk("midrst_crc_if", 64'({crc_byte, crc_feed, crc_init}), 64'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();

        // format error: only two words loaded
        write_word($urandom()); write_word($urandom());
        tf = total_feeds;
        pulse_ctrl(8'h12, 1'b1, 1'b0);
        m_fail = sat(m_fail);
        exp_q.push_back(exp_word(0, 1, 0, 0, 0, 0, 0));
        chk_sb("fmt_short");
        repeat (4) @(negedge clk);
        chk("fmt_short_nofeed", 64'(total_feeds), 64'(tf));

        // clear wins over simultaneous start
        pulse_ctrl(8'h12, 1'b1, 1'b1);
        model_clear();
        chk_sb("clear_wins");
        repeat (4) @(negedge clk);
        chk("clear_wins_nofeed", 64'(total_feeds), 64'(tf));

        // format error: nonzero pad byte in word2
        load($urandom(), $urandom(), 32'h00AB12CD);
        pulse_ctrl(8'h12, 1'b1, 1'b0);
        m_fail = sat(m_fail);
        exp_q.push_back(exp_word(0, 1, 0, 0, 0, 0, 0));
        chk_sb("fmt_pad");
        repeat (4) @(negedge clk);
        chk("fmt_pad_nofeed", 64'(total_feeds), 64'(tf));

        // top of the mono range blocks every successor
        pulse_ctrl(8'h00, 1'b0, 1'b1);
        model_clear();
        chk_sb("clear_plain");
        stall_en = 1'b1;
        make_record(8'h55, $urandom(), 32'hFFFF_FFFF, w0, w1, w2);
        run_record("mono_max", 8'h55, w0, w1, w2, lat);
        make_record(8'h55, $urandom(), 32'h0000_0000, w0, w1, w2);
        run_record("mono_wrap", 8'h55, w0, w1, w2, lat);
        chk("mono_wrap_err", 64'(stat_out[3]), 64'd1);

        // pass_count saturation
        pulse_ctrl(8'h00, 1'b0, 1'b1);
        model_clear();
        chk_sb("clear_sat");
        for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
            make_record(8'h21, $urandom(), 32'(i + 1), w0, w1, w2);
            run_record("sat_run", 8'h21, w0, w1, w2, lat);
        end
        chk("sat_pass_count", 64'(stat_out[31 -: CNT_W]), 64'(CNT_MAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
